// File: rtl/fetch_pkg.sv
// Shared types and constants for the KISC-V prefetching instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int PC_STEP_WORD = 1;
  localparam int PC_STEP_BYTE = 4;

  localparam logic [3:0] DSIZE_WORD = 4'b1111;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with synchronous flush; head reads as zero when empty.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rts,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push && !flush;
    do_pop  = pop && (cnt_q != '0) && !flush;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rts) begin
    if (!rts) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign head  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign level = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Prefetching instruction fetch front end: owns the PC, issues APB reads, queues words with their PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              PC_STEP   = 4
) (
  input  logic                       clk,
  input  logic                       rts,
  output logic                       mem_sel,
  output logic                       mem_en,
  output logic [XLEN-1:0]            mem_addr,
  output logic [3:0]                 mem_strb,
  input  logic [31:0]                mem_rdata,
  input  logic                       mem_ready,
  output logic                       ins_valid,
  output logic [31:0]                ins_data,
  output logic [XLEN-1:0]            ins_pc,
  input  logic                       ins_ready,
  input  logic                       redir_valid,
  input  logic [XLEN-1:0]            redir_pc,
  input  logic                       halt,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int              LW         = $clog2(DEPTH+1);
  localparam logic [LW-1:0]   DEPTH_L    = LW'(DEPTH);
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = (PC_STEP == PC_STEP_BYTE) ? ~XLEN'(3) : '1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            discard_q, discard_d;
  logic            misalign_q, misalign_d;

  logic            complete, push, pop, issue_ok, issue;
  logic [LW-1:0]   lvl_after;
  logic [XLEN+31:0] head;

  assign complete  = (state_q == ACCESS) && mem_ready;
  assign pop       = ins_valid && ins_ready;
  assign push      = complete && !discard_q && !redir_valid;
  // Occupancy once this edge's push/pop land; nothing else can be in flight at an issue edge.
  assign lvl_after = level + LW'(push) - LW'(pop);
  assign issue_ok  = !halt && !redir_valid && (lvl_after < DEPTH_L);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    discard_d  = discard_q;
    misalign_d = 1'b0;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_ok) begin
          state_d = SETUP;
          issue   = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (mem_ready) begin
          discard_d = 1'b0;
          if (issue_ok) begin
            state_d = SETUP;
            issue   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      mem_addr_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + STEP;
    end
    // A transfer still outstanding after this edge must have its data dropped.
    if (redir_valid) begin
      fetch_pc_d = redir_pc & ALIGN_MASK;
      misalign_d = (PC_STEP == PC_STEP_BYTE) && (redir_pc[1:0] != 2'b00);
      if ((state_q == SETUP) || ((state_q == ACCESS) && !mem_ready)) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rts) begin
    if (!rts) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_VEC;
      mem_addr_q <= RESET_VEC;
      discard_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      discard_q  <= discard_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(
    .W     (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rts       (rts),
    .push      (push),
    .push_data ({mem_addr_q, mem_rdata}),
    .pop       (pop),
    .flush     (redir_valid),
    .head      (head),
    .level     (level)
  );

  assign mem_sel      = (state_q != IDLE);
  assign mem_en       = (state_q == ACCESS);
  assign mem_addr     = mem_addr_q;
  assign mem_strb     = DSIZE_WORD;
  assign ins_valid    = (level != '0);
  assign ins_pc       = head[XLEN+31:32];
  assign ins_data     = head[31:0];
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (byte-addressed instance plus a word-addressed one).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rts;
  logic        mem_sel, mem_en, mem_ready, ins_valid, ins_ready, redir_valid, halt, misalign_err;
  logic [31:0] mem_addr, mem_rdata, ins_data, ins_pc, redir_pc;
  logic [3:0]  mem_strb;
  logic [2:0]  level;

  logic        mem_sel1, mem_en1, mem_ready1, ins_valid1, ins_ready1, redir_valid1, halt1, misalign_err1;
  logic [31:0] mem_addr1, mem_rdata1, ins_data1, ins_pc1, redir_pc1;
  logic [3:0]  mem_strb1;
  logic [2:0]  level1;

  int checks = 0;
  int errors = 0;
  int n_setup;

  always #5 clk = ~clk;

  assign mem_rdata  = {16'hC0DE, mem_addr[15:0]};
  assign mem_rdata1 = {16'hC0DE, mem_addr1[15:0]};

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_VEC(32'h0), .PC_STEP(4)) u_dut (
    .clk(clk), .rts(rts), .mem_sel(mem_sel), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_strb(mem_strb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc), .ins_ready(ins_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .halt(halt),
    .misalign_err(misalign_err), .level(level)
  );

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_VEC(32'h0), .PC_STEP(1)) u_dut1 (
    .clk(clk), .rts(rts), .mem_sel(mem_sel1), .mem_en(mem_en1), .mem_addr(mem_addr1),
    .mem_strb(mem_strb1), .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
    .ins_valid(ins_valid1), .ins_data(ins_data1), .ins_pc(ins_pc1), .ins_ready(ins_ready1),
    .redir_valid(redir_valid1), .redir_pc(redir_pc1), .halt(halt1),
    .misalign_err(misalign_err1), .level(level1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic count_setups(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (mem_sel && !mem_en) c++;
    end
  endtask

  initial begin
    rts = 1'b0; mem_ready = 1'b1; ins_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0; halt = 1'b0;
    mem_ready1 = 1'b1; ins_ready1 = 1'b1; redir_valid1 = 1'b0; redir_pc1 = '0; halt1 = 1'b1;
    tick(); tick();
    chk("rst_sel", {31'b0, mem_sel}, 32'd0);
    chk("rst_en", {31'b0, mem_en}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_strb", {28'b0, mem_strb}, 32'hF);
    chk("rst_valid", {31'b0, ins_valid}, 32'd0);
    chk("rst_data", ins_data, 32'h0);
    chk("rst_pc", ins_pc, 32'h0);
    chk("rst_level", {29'b0, level}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);

    // Streaming with zero-wait memory and an always-ready decoder
    rts = 1'b1;
    tick();
    chk("s_setup_sel", {31'b0, mem_sel}, 32'd1);
    chk("s_setup_en", {31'b0, mem_en}, 32'd0);
    chk("s_setup_addr", mem_addr, 32'h0);
    tick();
    chk("s_access_en", {31'b0, mem_en}, 32'd1);
    chk("s_access_valid", {31'b0, ins_valid}, 32'd0);
    tick();
    chk("s_first_valid", {31'b0, ins_valid}, 32'd1);
    chk("s_first_pc", ins_pc, 32'h0);
    chk("s_first_data", ins_data, 32'hC0DE0000);
    chk("s_next_addr", mem_addr, 32'h4);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("s_gap_valid", {31'b0, ins_valid}, 32'd0);
      chk("s_gap_addr", mem_addr, 32'(4 * k));
      tick();
      chk("s_word_valid", {31'b0, ins_valid}, 32'd1);
      chk("s_word_pc", ins_pc, 32'(4 * k));
      chk("s_word_data", ins_data, 32'hC0DE0000 | 32'(4 * k));
    end

    // Decoder stalled: buffer fills after exactly DEPTH transfers
    rts = 1'b0; ins_ready = 1'b0;
    tick();
    rts = 1'b1;
    count_setups(14, n_setup);
    chk("full_transfers", n_setup, 32'd4);
    chk("full_level", {29'b0, level}, 32'd4);
    chk("full_sel", {31'b0, mem_sel}, 32'd0);
    chk("full_head_pc", ins_pc, 32'h0);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    chk("pop1_addr", mem_addr, 32'h10);
    chk("pop1_sel", {31'b0, mem_sel}, 32'd1);
    chk("pop1_level", {29'b0, level}, 32'd3);
    chk("pop1_head", ins_pc, 32'h4);
    count_setups(6, n_setup);
    chk("pop1_transfers", n_setup, 32'd0);
    chk("pop1_refill", {29'b0, level}, 32'd4);

    // Redirect while a wait-stated ACCESS is in flight
    ins_ready = 1'b1; mem_ready = 1'b0;
    tick();
    ins_ready = 1'b0;
    chk("rd_setup_addr", mem_addr, 32'h14);
    tick();
    chk("rd_access", {31'b0, mem_en}, 32'd1);
    redir_valid = 1'b1; redir_pc = 32'h100;
    tick();
    redir_valid = 1'b0;
    chk("rd_flush_level", {29'b0, level}, 32'd0);
    chk("rd_still_access", {31'b0, mem_en}, 32'd1);
    chk("rd_addr_held", mem_addr, 32'h14);
    tick(); tick();
    chk("rd_wait_en", {31'b0, mem_en}, 32'd1);
    mem_ready = 1'b1;
    tick();
    chk("rd_dropped_level", {29'b0, level}, 32'd0);
    chk("rd_new_addr", mem_addr, 32'h100);
    chk("rd_new_setup", {31'b0, mem_sel & ~mem_en}, 32'd1);
    tick(); tick();
    chk("rd_new_pc", ins_pc, 32'h100);
    chk("rd_new_data", ins_data, 32'hC0DE0100);

    // Redirect coinciding with completion and pop at level 2
    tick(); tick(); tick();
    chk("rc_level2", {29'b0, level}, 32'd2);
    chk("rc_access", {31'b0, mem_en}, 32'd1);
    ins_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h200;
    tick();
    redir_valid = 1'b0;
    chk("rc_level0", {29'b0, level}, 32'd0);
    chk("rc_valid0", {31'b0, ins_valid}, 32'd0);
    chk("rc_idle", {31'b0, mem_sel}, 32'd0);
    tick();
    chk("rc_addr", mem_addr, 32'h200);
    tick(); tick();
    chk("rc_pc", ins_pc, 32'h200);
    chk("rc_misalign_quiet", {31'b0, misalign_err}, 32'd0);

    // Misaligned redirect during SETUP on the byte-addressed unit
    redir_valid = 1'b1; redir_pc = 32'h102;
    tick();
    redir_valid = 1'b0;
    chk("ma_pulse", {31'b0, misalign_err}, 32'd1);
    chk("ma_access", {31'b0, mem_en}, 32'd1);
    tick();
    chk("ma_pulse_end", {31'b0, misalign_err}, 32'd0);
    chk("ma_addr", mem_addr, 32'h100);
    chk("ma_level", {29'b0, level}, 32'd0);
    tick(); tick();
    chk("ma_pc", ins_pc, 32'h100);

    // halt asserted mid-ACCESS lets the transfer finish but blocks the next one
    tick();
    halt = 1'b1; mem_ready = 1'b0;
    chk("h_access", {31'b0, mem_en}, 32'd1);
    tick();
    mem_ready = 1'b1;
    tick();
    chk("h_done_pc", ins_pc, 32'h104);
    chk("h_done_sel", {31'b0, mem_sel}, 32'd0);
    count_setups(4, n_setup);
    chk("h_blocked", n_setup, 32'd0);
    chk("h_drained", {29'b0, level}, 32'd0);
    halt = 1'b0;
    tick();
    chk("h_resume_addr", mem_addr, 32'h108);

    // Asynchronous reset in the middle of ACCESS
    mem_ready = 1'b0;
    tick();
    chk("ar_access", {31'b0, mem_en}, 32'd1);
    rts = 1'b0;
    #1;
    chk("ar_sel", {31'b0, mem_sel}, 32'd0);
    chk("ar_en", {31'b0, mem_en}, 32'd0);
    chk("ar_addr", mem_addr, 32'h0);
    tick();
    rts = 1'b1; mem_ready = 1'b1;
    tick();
    chk("ar_restart_addr", mem_addr, 32'h0);
    chk("ar_restart_sel", {31'b0, mem_sel}, 32'd1);
    tick(); tick();
    chk("ar_restart_pc", ins_pc, 32'h0);

    // Word-addressed unit: unaligned target is legal
    chk("w_idle", {31'b0, mem_sel1}, 32'd0);
    redir_valid1 = 1'b1; redir_pc1 = 32'h103;
    tick();
    redir_valid1 = 1'b0; halt1 = 1'b0;
    chk("w_no_err", {31'b0, misalign_err1}, 32'd0);
    tick();
    chk("w_addr0", mem_addr1, 32'h103);
    tick(); tick();
    chk("w_pc", ins_pc1, 32'h103);
    chk("w_data", ins_data1, 32'hC0DE0103);
    chk("w_addr1", mem_addr1, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the KISC-V core. It replaces the single-word, PC-plus-one fetch path with a prefetching fetcher.
- Owns the program counter and issues APB-style read transfers to the sram port. Fetched words are queued with their PC in a DEPTH-entry prefetch buffer.
- Accepts redirects from the branch/jump resolver (JAL, JALR, Bxx) and flushes stale instructions on each redirect.

Parameters:
- XLEN, 32, address/PC width.
- DEPTH, 4, prefetch buffer entries; power of two, >= 2.
- RESET_VEC, 0, PC after reset.
- PC_STEP, 4, PC increment per fetched word; legal values 1 (word-addressed) or 4 (byte-addressed).

Ports:
- clk  in  1  clock, rising edge.
- rts  in  1  reset, asynchronous, active-low.
- mem_sel  out  1  APB select.
- mem_en  out  1  APB enable.
- mem_addr  out  XLEN  fetch address.
- mem_strb  out  4  byte lanes; constant 4'b1111.
- mem_rdata  in  32  read data.
- mem_ready  in  1  transfer complete, sampled only in ACCESS.
- ins_valid  out  1  buffer head valid.
- ins_data  out  32  head instruction.
- ins_pc  out  XLEN  PC of head instruction.
- ins_ready  in  1  decoder consumes head.
- redir_valid  in  1  redirect request, single-cycle.
- redir_pc  in  XLEN  redirect target.
- halt  in  1  block new transfers.
- misalign_err  out  1  one-cycle pulse on a misaligned redirect.
- level  out  $clog2(DEPTH+1)  buffer occupancy.

Behaviour:
- Reset (rts=0, asynchronous): state=IDLE, fetch_pc=RESET_VEC, mem_addr=RESET_VEC, discard=0, buffer empty. All outputs 0 except mem_addr=RESET_VEC and mem_strb=4'b1111.
- State encoding:
  - mem_sel = (state != IDLE).
  - mem_en = (state == ACCESS).
  - mem_addr is registered and stable through SETUP and ACCESS.
- FSM transitions:
  - IDLE -> SETUP when issue_ok.
  - SETUP -> ACCESS unconditionally.
  - ACCESS holds while mem_ready=0.
  - ACCESS with mem_ready=1 -> SETUP if issue_ok, else IDLE.
- issue_ok = !halt && !redir_valid && (occupancy after this edge's push/pop + 0 in flight) < DEPTH. No transfer starts unless its word has a guaranteed slot, so a push never meets a full buffer.
- Issue edge: mem_addr <= fetch_pc; fetch_pc <= fetch_pc + PC_STEP, with XLEN wrap-around (all-ones + step wraps to low addresses, no flag).
- Completion (ACCESS && mem_ready): push {mem_addr, mem_rdata} unless discard=1 or redir_valid=1 that cycle; clear discard.
- Zero-wait memory yields one word per 2 cycles. The first word appears on ins_valid 3 cycles after rts deassert: SETUP, ACCESS, then visible.
- Pop: ins_valid && ins_ready removes the head. Simultaneous push and pop keep level unchanged.
- Redirect (redir_valid=1):
  - Buffer flushed at the edge; flush beats a same-cycle pop or push.
  - fetch_pc <= redir_pc.
  - If state is SETUP, or ACCESS without mem_ready, set discard=1. An in-flight transfer is never aborted; its data is dropped on completion.
  - No new issue that cycle.
  - Back-to-back redirects: the last one wins.
- Misaligned redirect: if PC_STEP=4 and redir_pc[1:0] != 0, fetch_pc takes redir_pc with [1:0] forced to 0, and misalign_err=1 for exactly that next cycle.
- halt: blocks issue only. A transfer in flight completes normally; redirects and pops still act.
- ins_valid = level != 0. ins_data/ins_pc are held stable while ins_valid && !ins_ready.
- Reset asserted mid-transfer: immediate return to IDLE; mem_sel/mem_en drop asynchronously.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, SETUP, ACCESS}.
  - PC_STEP legal-value constants.
  - DSIZE_WORD = 4'b1111.
- Sub-module fetch_fifo: synchronous FIFO with synchronous flush, width XLEN+32, depth DEPTH, outputs head/level. Its reset is the same asynchronous active-low rts.

Test Plan:
- Reset release, mem_ready tied 1, ins_ready=1 -> mem_addr 0,4,8,12 on successive SETUPs. Words appear with ins_pc 0,4,8,12, one every 2 cycles; first ins_valid on cycle 3.
- ins_ready=0, DEPTH=4 -> exactly 4 transfers, then IDLE with mem_sel=0, level=4. Raising ins_ready for one cycle -> exactly one new transfer at address 16.
- Redirect to 0x100 during ACCESS with mem_ready held 0 for 3 cycles -> that word is dropped and level=0. Next mem_addr=0x100 and the next ins_pc=0x100.
- Redirect in the same cycle as completion and pop at level=2 -> level=0 next cycle and nothing pushed.
- PC_STEP=4, redir_pc=0x102 -> misalign_err pulses once, next fetch address 0x100. With PC_STEP=1, redir_pc=0x103 -> no error, fetch at 0x103, 0x104.
- halt=1 mid-ACCESS -> that transfer completes, no further SETUP. rts pulsed low mid-ACCESS -> mem_sel=0 immediately, then restart from RESET_VEC.
